// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single Dcache request port between NUM_LD
// load units and one store unit. One grant is held until Dcache_finish; the
// finish is routed back to the granted unit only.
// Optional build macro DCACHE_ARB_STARVE_GUARD_EN: after STARVE_LIMIT
// consecutive store grants with a load waiting, loads win the next arbitration.
module dcache_port_arbiter #(
    parameter int NUM_LD       = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2*NUM_LD-1:0]    ld_command,
    input  logic [XLEN*NUM_LD-1:0] ld_addr,
    input  logic [3*NUM_LD-1:0]    ld_mem_size,
    input  logic [1:0]             st_command,
    input  logic [XLEN-1:0]        st_addr,
    input  logic [63:0]            st_data,
    input  logic [2:0]             st_mem_size,
    input  logic [63:0]            Dcache2proc_data,
    input  logic                   Dcache_finish,
    output logic [1:0]             proc2Dcache_command,
    output logic [XLEN-1:0]        proc2Dcache_addr,
    output logic [63:0]            proc2Dcache_data,
    output logic [2:0]             proc2Dcache_size,
    output logic [NUM_LD-1:0]      ld_finish,
    output logic [63:0]            ld_data,
    output logic                   st_finish,
    output logic                   arb_busy
);

    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;
    localparam int RRW = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e          state_q, state_d;
    logic            own_st_q, own_st_d;
    logic [RRW-1:0]  own_ld_q, own_ld_d;
    logic [RRW-1:0]  rr_q, rr_d;
    logic            flush_q;
    logic [1:0]      lat_cmd_q, lat_cmd_d;
    logic [XLEN-1:0] lat_addr_q, lat_addr_d;
    logic [63:0]     lat_data_q, lat_data_d;
    logic [2:0]      lat_size_q, lat_size_d;

    logic [NUM_LD-1:0] ld_req;
    logic              st_req;
    logic              ld_found;
    logic [RRW-1:0]    ld_win;
    logic              ld_first;
    logic              win_st, win_ld;
    logic              sel_st;
    logic [RRW-1:0]    sel_ld;
    logic              cur_req;
    logic [1:0]        cur_cmd;
    logic [XLEN-1:0]   cur_addr;
    logic [63:0]       cur_data;
    logic [2:0]        cur_size;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    assign ld_first = (starve_q == SW'(STARVE_LIMIT));
`else
    // Store always wins; STARVE_LIMIT has no effect in this build.
    assign ld_first = (STARVE_LIMIT < 0);
`endif

    // Request decode and round-robin load pick starting at rr_q.
    always_comb begin
        st_req   = (st_command == BUS_STORE);
        ld_req   = '0;
        ld_found = 1'b0;
        ld_win   = rr_q;
        for (int i = 0; i < NUM_LD; i++)
            ld_req[i] = (ld_command[2*i +: 2] == BUS_LOAD);
        for (int k = 0; k < NUM_LD; k++) begin
            if (!ld_found && ld_req[(int'(rr_q) + k) % NUM_LD]) begin
                ld_found = 1'b1;
                ld_win   = RRW'((int'(rr_q) + k) % NUM_LD);
            end
        end
    end

    assign win_st = st_req && !(ld_first && ld_found);
    assign win_ld = ld_found && !win_st;

    // Fields of the unit currently selected: the winner in IDLE, the owner in BUSY.
    always_comb begin
        sel_st   = (state_q == BUSY) ? own_st_q : win_st;
        sel_ld   = (state_q == BUSY) ? own_ld_q : ld_win;
        cur_req  = sel_st ? st_req      : ld_req[sel_ld];
        cur_cmd  = sel_st ? st_command  : ld_command[2*int'(sel_ld) +: 2];
        cur_addr = sel_st ? st_addr     : ld_addr[XLEN*int'(sel_ld) +: XLEN];
        cur_data = sel_st ? st_data     : 64'd0;
        cur_size = sel_st ? st_mem_size : ld_mem_size[3*int'(sel_ld) +: 3];
    end

    // Next state, Dcache drive and finish routing; a cycle right after reset is fully masked.
    always_comb begin
        state_d             = state_q;
        own_st_d            = own_st_q;
        own_ld_d            = own_ld_q;
        rr_d                = rr_q;
        lat_cmd_d           = lat_cmd_q;
        lat_addr_d          = lat_addr_q;
        lat_data_d          = lat_data_q;
        lat_size_d          = lat_size_q;
        proc2Dcache_command = BUS_NONE;
        proc2Dcache_addr    = '0;
        proc2Dcache_data    = '0;
        proc2Dcache_size    = '0;
        ld_finish           = '0;
        st_finish           = 1'b0;
        arb_busy            = (state_q == BUSY);
        ld_data             = flush_q ? 64'd0 : Dcache2proc_data;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
        starve_d            = starve_q;
`endif
        if (flush_q) begin
            state_d  = IDLE;
            arb_busy = 1'b0;
        end else if (state_q == IDLE) begin
            if (win_st || win_ld) begin
                proc2Dcache_command = cur_cmd;
                proc2Dcache_addr    = cur_addr;
                proc2Dcache_data    = cur_data;
                proc2Dcache_size    = cur_size;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
                if (win_st && !ld_found)
                    starve_d = '0;
                else if (win_st && !ld_first)
                    starve_d = starve_q + 1'b1;
                else if (win_ld)
                    starve_d = '0;
`endif
                if (!Dcache_finish) begin
                    state_d    = BUSY;
                    own_st_d   = win_st;
                    own_ld_d   = ld_win;
                    lat_cmd_d  = cur_cmd;
                    lat_addr_d = cur_addr;
                    lat_data_d = cur_data;
                    lat_size_d = cur_size;
                end
            end
        end else begin
            // Owner squashed its request: keep presenting what the Dcache already accepted.
            if (cur_req) begin
                proc2Dcache_command = cur_cmd;
                proc2Dcache_addr    = cur_addr;
                proc2Dcache_data    = cur_data;
                proc2Dcache_size    = cur_size;
                lat_cmd_d           = cur_cmd;
                lat_addr_d          = cur_addr;
                lat_data_d          = cur_data;
                lat_size_d          = cur_size;
            end else begin
                proc2Dcache_command = lat_cmd_q;
                proc2Dcache_addr    = lat_addr_q;
                proc2Dcache_data    = lat_data_q;
                proc2Dcache_size    = lat_size_q;
            end
            if (Dcache_finish)
                state_d = IDLE;
        end
        // Completion: either a single-cycle hit in IDLE or the end of a BUSY hold.
        if (!flush_q && Dcache_finish && ((state_q == BUSY) || win_st || win_ld)) begin
            if (sel_st) begin
                st_finish = 1'b1;
            end else begin
                ld_finish[sel_ld] = 1'b1;
                rr_d = (int'(sel_ld) == NUM_LD - 1) ? '0 : sel_ld + 1'b1;
            end
        end
    end

    // State, owner, round-robin pointer and latched request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            own_st_q   <= 1'b0;
            own_ld_q   <= '0;
            rr_q       <= '0;
            flush_q    <= 1'b1;
            lat_cmd_q  <= BUS_NONE;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_size_q <= '0;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            own_st_q   <= own_st_d;
            own_ld_q   <= own_ld_d;
            rr_q       <= rr_d;
            flush_q    <= 1'b0;
            lat_cmd_q  <= lat_cmd_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            lat_size_q <= lat_size_d;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
            starve_q   <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: vector table of single-cycle arbitrations,
// hand-written multi-cycle sequences, then random traffic against a reference model.
module tb_dcache_port_arbiter;

    localparam int NL = 2;
    localparam int XL = 32;
    localparam int SLIM = 4;
    localparam logic [1:0] N = 2'd0, L = 2'd1, S = 2'd2;

    logic            clock = 1'b0;
    logic            reset;
    logic [2*NL-1:0] ld_command;
    logic [XL*NL-1:0] ld_addr;
    logic [3*NL-1:0] ld_mem_size;
    logic [1:0]      st_command;
    logic [XL-1:0]   st_addr;
    logic [63:0]     st_data;
    logic [2:0]      st_mem_size;
    logic [63:0]     d2p;
    logic            fin;
    logic [1:0]      p_cmd;
    logic [XL-1:0]   p_addr;
    logic [63:0]     p_data;
    logic [2:0]      p_size;
    logic [NL-1:0]   ld_finish;
    logic [63:0]     ld_data;
    logic            st_finish;
    logic            arb_busy;

    int checks = 0;
    int failures = 0;

    dcache_port_arbiter #(.NUM_LD(NL), .STARVE_LIMIT(SLIM), .XLEN(XL)) dut (
        .clock(clock), .reset(reset),
        .ld_command(ld_command), .ld_addr(ld_addr), .ld_mem_size(ld_mem_size),
        .st_command(st_command), .st_addr(st_addr), .st_data(st_data), .st_mem_size(st_mem_size),
        .Dcache2proc_data(d2p), .Dcache_finish(fin),
        .proc2Dcache_command(p_cmd), .proc2Dcache_addr(p_addr),
        .proc2Dcache_data(p_data), .proc2Dcache_size(p_size),
        .ld_finish(ld_finish), .ld_data(ld_data), .st_finish(st_finish), .arb_busy(arb_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ld_command = '0; ld_addr = '0; ld_mem_size = '0;
        st_command = N; st_addr = '0; st_data = '0; st_mem_size = '0;
        fin = 1'b0; d2p = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        nxt();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  c0, c1, cs;
        logic        f;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [1:0]  e_ldf;
        logic        e_stf;
    } vec_t;
    vec_t tbl[10];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [2:0]  size;
    } req_t;

    int   m_own;   // -1 = no grant, 0..NL-1 = load, NL = store
    int   m_rr;
    int   m_starve;
    req_t m_lat;

    function automatic bit is_req(int u);
        if (u == NL) return st_command == S;
        return ld_command[2*u +: 2] == L;
    endfunction

    function automatic req_t unit_fields(int u);
        req_t r;
        if (u == NL) r = '{st_command, st_addr, st_data, st_mem_size};
        else r = '{ld_command[2*u +: 2], ld_addr[XL*u +: XL], 64'd0, ld_mem_size[3*u +: 3]};
        return r;
    endfunction

    task automatic model_step(output req_t e, output logic [NL-1:0] eldf, output logic estf,
                              output logic ebusy);
        int done;
        e = '0; eldf = '0; estf = 1'b0; ebusy = (m_own >= 0); done = -1;
        if (m_own < 0) begin
            int ldw, sel;
            bit ldfirst;
            ldw = -1; sel = -1; ldfirst = 1'b0;
`ifdef DCACHE_ARB_STARVE_GUARD_EN
            ldfirst = (m_starve >= SLIM);
`endif
            for (int k = 0; k < NL; k++)
                if (ldw < 0 && is_req((m_rr + k) % NL)) ldw = (m_rr + k) % NL;
            if (is_req(NL) && !(ldfirst && ldw >= 0)) sel = NL;
            else sel = ldw;
            if (sel == NL) m_starve = (ldw >= 0) ? ((m_starve < SLIM) ? m_starve + 1 : SLIM) : 0;
            else if (sel >= 0) m_starve = 0;
            if (sel >= 0) begin
                e = unit_fields(sel);
                if (fin) done = sel;
                else begin m_own = sel; m_lat = e; end
            end
        end else begin
            if (is_req(m_own)) begin e = unit_fields(m_own); m_lat = e; end
            else e = m_lat;
            if (fin) begin done = m_own; m_own = -1; end
        end
        if (done == NL) estf = 1'b1;
        else if (done >= 0) begin eldf[done] = 1'b1; m_rr = (done + 1) % NL; end
    endtask

    // random unit state
    bit ld_act[NL], ld_dead[NL];
    bit st_act, st_dead;
    logic [NL-1:0] prev_ldf;
    logic prev_stf;

    initial begin
        req_t e;
        logic [NL-1:0] eldf;
        logic estf, ebusy;

        reset = 1'b1;
        clear_inputs();

        // Reset state: the cycle after reset is sampled shows all outputs idle,
        // even with a stray Dcache_finish and nonzero read data.
        fin = 1'b1; d2p = 64'h55;
        nxt();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_cmd", p_cmd, N);
        chk("rst_addr", p_addr, 0);
        chk("rst_data", p_data, 0);
        chk("rst_ldf", ld_finish, 0);
        chk("rst_stf", st_finish, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_lddata", ld_data, 0);
        nxt();
        @(negedge clock);
        chk("idle_fin_ldf", ld_finish, 0);
        chk("idle_fin_stf", st_finish, 0);
        chk("idle_lddata", ld_data, 64'h55);
        nxt();

        // Single-cycle hits (finish every cycle) keep the arbiter in IDLE; order
        // exercises rr wrap, store priority without rr update and non-request encodings.
        tbl[0] = '{N, N, N, 1'b1, N, 32'h0,   2'b00, 1'b0};
        tbl[1] = '{L, L, N, 1'b1, L, 32'h300, 2'b01, 1'b0};
        tbl[2] = '{L, L, N, 1'b1, L, 32'h100, 2'b10, 1'b0};
        tbl[3] = '{L, L, N, 1'b1, L, 32'h300, 2'b01, 1'b0};
        tbl[4] = '{L, L, S, 1'b1, S, 32'h200, 2'b00, 1'b1};
        tbl[5] = '{L, N, N, 1'b1, L, 32'h300, 2'b01, 1'b0};
        tbl[6] = '{L, 2'd3, N, 1'b1, L, 32'h300, 2'b01, 1'b0};
        tbl[7] = '{N, S, N, 1'b1, N, 32'h0,   2'b00, 1'b0};
        tbl[8] = '{N, L, N, 1'b1, L, 32'h100, 2'b10, 1'b0};
        tbl[9] = '{L, L, N, 1'b1, L, 32'h300, 2'b01, 1'b0};
        do_reset();
        for (int v = 0; v < 10; v++) begin
            ld_addr = {32'h100, 32'h300};
            ld_mem_size = {3'd3, 3'd2};
            st_addr = 32'h200; st_data = 64'hDEAD_BEEF_0000_0001; st_mem_size = 3'd1;
            ld_command = {tbl[v].c1, tbl[v].c0};
            st_command = tbl[v].cs;
            fin = tbl[v].f;
            @(negedge clock);
            chk($sformatf("tbl%0d_cmd", v), p_cmd, tbl[v].e_cmd);
            chk($sformatf("tbl%0d_addr", v), p_addr, tbl[v].e_addr);
            chk($sformatf("tbl%0d_data", v), p_data, (tbl[v].e_cmd == S) ? st_data : 64'd0);
            chk($sformatf("tbl%0d_ldf", v), ld_finish, tbl[v].e_ldf);
            chk($sformatf("tbl%0d_stf", v), st_finish, tbl[v].e_stf);
            chk($sformatf("tbl%0d_busy", v), arb_busy, 0);
            nxt();
        end

        // Single load 1, finish three cycles after the grant.
        do_reset();
        ld_command[3:2] = L; ld_addr[63:32] = 32'h100; ld_mem_size[5:3] = 3'd2;
        d2p = 64'h1234_5678_9ABC_DEF0;
        @(negedge clock);
        chk("s1_cmd", p_cmd, L);
        chk("s1_addr", p_addr, 32'h100);
        chk("s1_size", p_size, 3'd2);
        chk("s1_busy0", arb_busy, 0);
        nxt();
        for (int c = 1; c <= 3; c++) begin
            fin = (c == 3);
            @(negedge clock);
            chk($sformatf("s1_c%0d_cmd", c), p_cmd, L);
            chk($sformatf("s1_c%0d_busy", c), arb_busy, 1);
            chk($sformatf("s1_c%0d_ldf", c), ld_finish, (c == 3) ? 2'b10 : 2'b00);
            chk($sformatf("s1_c%0d_lddata", c), ld_data, d2p);
            nxt();
        end
        ld_command = '0; fin = 1'b0;
        @(negedge clock);
        chk("s1_end_busy", arb_busy, 0);
        chk("s1_end_cmd", p_cmd, N);
        chk("s1_end_ldf", ld_finish, 0);
        nxt();

        // Store and load 0 together: store first, load on the cycle after st_finish.
        do_reset();
        st_command = S; st_addr = 32'h200; st_data = 64'hCAFE_F00D_1111_2222; st_mem_size = 3'd3;
        ld_command[1:0] = L; ld_addr[31:0] = 32'h300; ld_mem_size[2:0] = 3'd1;
        @(negedge clock);
        chk("s2_cmd", p_cmd, S);
        chk("s2_addr", p_addr, 32'h200);
        chk("s2_data", p_data, 64'hCAFE_F00D_1111_2222);
        chk("s2_size", p_size, 3'd3);
        nxt();
        fin = 1'b1;
        @(negedge clock);
        chk("s2_stf", st_finish, 1);
        chk("s2_ldf_quiet", ld_finish, 0);
        chk("s2_busy", arb_busy, 1);
        nxt();
        st_command = N;
        @(negedge clock);
        chk("s2_ld_cmd", p_cmd, L);
        chk("s2_ld_addr", p_addr, 32'h300);
        chk("s2_ld_data", p_data, 0);
        chk("s2_ld_size", p_size, 3'd1);
        chk("s2_ld_busy", arb_busy, 0);
        chk("s2_ld_ldf", ld_finish, 2'b01);
        nxt();

        // Squash mid-BUSY: load 0 drops after one cycle; load 1 arrives and must wait.
        do_reset();
        ld_command[1:0] = L; ld_addr[31:0] = 32'h40; ld_mem_size[2:0] = 3'd2;
        @(negedge clock);
        chk("s3_c0_addr", p_addr, 32'h40);
        nxt();
        ld_command[1:0] = N; ld_addr[31:0] = 32'hFFF0; ld_mem_size[2:0] = 3'd0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin ld_command[3:2] = L; ld_addr[63:32] = 32'h500; end
            fin = (c == 4);
            @(negedge clock);
            chk($sformatf("s3_c%0d_cmd", c), p_cmd, L);
            chk($sformatf("s3_c%0d_addr", c), p_addr, 32'h40);
            chk($sformatf("s3_c%0d_size", c), p_size, 3'd2);
            chk($sformatf("s3_c%0d_ldf", c), ld_finish, (c == 4) ? 2'b01 : 2'b00);
            nxt();
        end
        fin = 1'b0;
        @(negedge clock);
        chk("s3_c5_busy", arb_busy, 0);
        chk("s3_c5_cmd", p_cmd, L);
        chk("s3_c5_addr", p_addr, 32'h500);
        nxt();

        // Reset during a store grant; the finish arriving afterwards is dropped.
        do_reset();
        st_command = S; st_addr = 32'h200; st_data = 64'h77; st_mem_size = 3'd3;
        d2p = 64'hABCD;
        @(negedge clock);
        chk("s4_cmd", p_cmd, S);
        nxt();
        @(negedge clock);
        chk("s4_busy", arb_busy, 1);
        reset = 1'b1;
        nxt();
        reset = 1'b0; fin = 1'b1;
        @(negedge clock);
        chk("s4_flush_cmd", p_cmd, N);
        chk("s4_flush_addr", p_addr, 0);
        chk("s4_flush_data", p_data, 0);
        chk("s4_flush_size", p_size, 0);
        chk("s4_flush_stf", st_finish, 0);
        chk("s4_flush_busy", arb_busy, 0);
        chk("s4_flush_lddata", ld_data, 0);
        nxt();
        st_command = N; fin = 1'b0;
        @(negedge clock);
        chk("s4_after_busy", arb_busy, 0);
        chk("s4_after_cmd", p_cmd, N);
        nxt();

`ifdef DCACHE_ARB_STARVE_GUARD_EN
        // Starvation guard: store and load 0 both request continuously with hits.
        do_reset();
        st_command = S; st_addr = 32'h200; ld_command[1:0] = L; ld_addr[31:0] = 32'h300;
        fin = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk($sformatf("sg%0d_stf", c), st_finish, (c == 4) ? 1'b0 : 1'b1);
            chk($sformatf("sg%0d_ldf", c), ld_finish, (c == 4) ? 2'b01 : 2'b00);
            nxt();
        end
`endif

        // Random traffic against the reference model.
        do_reset();
        m_own = -1; m_rr = 0; m_starve = 0; m_lat = '0;
        for (int i = 0; i < NL; i++) begin ld_act[i] = 0; ld_dead[i] = 0; end
        st_act = 0; st_dead = 0; prev_ldf = '0; prev_stf = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < NL; i++) begin
                if (prev_ldf[i]) begin
                    ld_act[i] = 0; ld_dead[i] = 0; ld_command[2*i +: 2] = N;
                end else if (ld_act[i]) begin
                    if ($urandom_range(0, 99) < 4) begin
                        ld_act[i] = 0; ld_dead[i] = (m_own == i);
                        ld_command[2*i +: 2] = N; ld_addr[XL*i +: XL] = $urandom;
                    end
                end else if (!ld_dead[i] && $urandom_range(0, 99) < 30) begin
                    ld_act[i] = 1;
                    ld_command[2*i +: 2] = L;
                    ld_addr[XL*i +: XL] = $urandom;
                    ld_mem_size[3*i +: 3] = 3'($urandom_range(0, 3));
                end else begin
                    ld_command[2*i +: 2] = ($urandom_range(0, 9) == 0) ? 2'd3 : N;
                end
            end
            if (prev_stf) begin
                st_act = 0; st_dead = 0; st_command = N;
            end else if (st_act) begin
                if ($urandom_range(0, 99) < 4) begin
                    st_act = 0; st_dead = (m_own == NL); st_command = N; st_addr = $urandom;
                end
            end else if (!st_dead && $urandom_range(0, 99) < 25) begin
                st_act = 1; st_command = S; st_addr = $urandom;
                st_data = {$urandom, $urandom}; st_mem_size = 3'($urandom_range(0, 3));
            end else begin
                st_command = ($urandom_range(0, 9) == 0) ? L : N;
            end
            fin = ($urandom_range(0, 99) < 35);
            d2p = {$urandom, $urandom};
            @(negedge clock);
            model_step(e, eldf, estf, ebusy);
            chk("rnd_cmd", p_cmd, e.cmd);
            chk("rnd_addr", p_addr, e.addr);
            chk("rnd_data", p_data, e.data);
            chk("rnd_size", p_size, e.size);
            chk("rnd_ldf", ld_finish, eldf);
            chk("rnd_stf", st_finish, estf);
            chk("rnd_busy", arb_busy, ebusy);
            chk("rnd_lddata", ld_data, d2p);
            prev_ldf = eldf; prev_stf = estf;
            nxt();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
